// File: rtl/layer_seq_pkg.sv
// Shared types and constants for the dense-layer MAC sequencer.
//   state_e   : sequencer FSM states
//   *_W       : datapath widths (product, accumulator, activation)
//   quant consts: saturation value, fraction shift, overflow bit window
//   bw_min1   : clog2 clamped to a minimum of 1 bit
//   sext_prod : sign-extend a 16-bit product/bias into the accumulator width
package layer_seq_pkg;

  typedef enum logic [2:0] {LOAD, MAC, DRAIN, QUANT, OUT} state_e;

  localparam int PROD_W  = 16;
  localparam int ACC_W   = 23;
  localparam int ACT_W   = 8;

  localparam int SAT_VAL = 127;
  localparam int FRAC_SH = 6;
  localparam int OVF_HI  = 21;
  localparam int OVF_LO  = 13;

  function automatic int bw_min1(input int v);
    return (v < 2) ? 1 : $clog2(v);
  endfunction

  function automatic logic signed [ACC_W-1:0] sext_prod(input logic signed [PROD_W-1:0] v);
    return {{(ACC_W-PROD_W){v[PROD_W-1]}}, v};
  endfunction

endpackage

// File: rtl/act_quant.sv
// Combinational activation quantizer: 23-bit signed accumulator -> 0..127.
//   acc_i : signed accumulator value
//   q_o   : quantized activation
//   sat_o : high when the result was forced to 127 (overflow or rounding carry)
module act_quant
  import layer_seq_pkg::*;
(
  input  logic signed [ACC_W-1:0] acc_i,
  output logic        [ACT_W-1:0] q_o,
  output logic                    sat_o
);

  logic [ACT_W-1:0] rnd;
  logic             unused_lsbs;

  // Below the rounding bit the fraction has no effect on the result.
  assign unused_lsbs = ^acc_i[FRAC_SH-2:0];

  // Bit OVF_LO is known zero on the path that uses rnd, so rnd tops out at 128.
  assign rnd = acc_i[OVF_LO:FRAC_SH] + ACT_W'(acc_i[FRAC_SH-1]);

  always_comb begin
    q_o   = '0;
    sat_o = 1'b0;
    if (acc_i[ACC_W-1]) begin
      q_o = '0;
    end else if (acc_i[OVF_HI:OVF_LO] != '0) begin
      q_o   = ACT_W'(SAT_VAL);
      sat_o = 1'b1;
    end else if (rnd[ACT_W-1]) begin
      q_o   = ACT_W'(SAT_VAL);
      sat_o = 1'b1;
    end else begin
      q_o = rnd;
    end
  end

endmodule

// File: rtl/layer_mac_sequencer.sv
// Time-multiplexed dense-layer evaluator using one shared 8x8 signed MAC.
// Loads NUM_IN activation bytes, then for each of NUM_OUT neurons reads weights
// and a bias from an external synchronous ROM (1-cycle latency), accumulates,
// quantizes and streams the 8-bit result out.
// Ports:
//   clk, reset            : clock, synchronous active-high reset
//   in_valid/in_ready/in_data    : activation input stream (ready only in LOAD)
//   w_addr/w_data         : weight ROM, w_addr = n*NUM_IN + c, data next cycle
//   b_addr/b_data         : bias ROM, b_addr = n, data next cycle
//   out_valid/out_ready/out_data/out_idx : result stream with neuron index
//   busy                  : high outside LOAD
//   done                  : one-cycle pulse after the last neuron is accepted
//   sat_cnt               : saturation counter, present only with LAYER_SEQ_SAT_CNT_EN
// Handshake: a transfer happens on a rising edge where valid and ready are both
// high; the source holds valid and data stable until that edge.
// Optional feature macro: LAYER_SEQ_SAT_CNT_EN.
module layer_mac_sequencer
  import layer_seq_pkg::*;
#(
  parameter int NUM_IN  = 30,
  parameter int NUM_OUT = 16,
  parameter int WA_W    = bw_min1(NUM_IN * NUM_OUT),
  parameter int BA_W    = bw_min1(NUM_OUT)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic signed [ACT_W-1:0]  in_data,
  output logic        [WA_W-1:0]   w_addr,
  input  logic signed [ACT_W-1:0]  w_data,
  output logic        [BA_W-1:0]   b_addr,
  input  logic signed [PROD_W-1:0] b_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic        [ACT_W-1:0]  out_data,
  output logic        [BA_W-1:0]   out_idx,
  output logic                     busy,
  output logic                     done
`ifdef LAYER_SEQ_SAT_CNT_EN
  ,
  output logic        [15:0]       sat_cnt
`endif
);

  localparam int CI_W = bw_min1(NUM_IN);
  localparam logic [CI_W-1:0] LAST_C = CI_W'(NUM_IN - 1);
  localparam logic [BA_W-1:0] LAST_N = BA_W'(NUM_OUT - 1);

  state_e                   state_q, state_d;
  logic [CI_W-1:0]          k_q, k_d, c_q, c_d;
  logic [BA_W-1:0]          n_q, n_d;
  logic [WA_W-1:0]          wa_q, wa_d;
  // Data-phase flags: the ROM word addressed last cycle is on w_data/b_data now.
  logic                     dv_q, dv_d, first_q, first_d;
  logic signed [ACT_W-1:0]  a_q, a_d;
  logic signed [ACC_W-1:0]  acc_q, acc_d;
  logic [ACT_W-1:0]         od_q, od_d;
  logic [BA_W-1:0]          oi_q, oi_d;
  logic                     ov_q, ov_d, done_q, done_d;
  logic signed [ACT_W-1:0]  buf_q [NUM_IN];
  logic signed [PROD_W-1:0] prod;
  logic [ACT_W-1:0]         q_val;
  logic                     q_sat;

  assign prod = a_q * w_data;

  act_quant u_quant (
    .acc_i (acc_q),
    .q_o   (q_val),
    .sat_o (q_sat)
  );

  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    c_d     = c_q;
    n_d     = n_q;
    wa_d    = wa_q;
    dv_d    = 1'b0;
    first_d = 1'b0;
    a_d     = a_q;
    acc_d   = acc_q;
    od_d    = od_q;
    oi_d    = oi_q;
    ov_d    = ov_q;
    done_d  = 1'b0;

    // The first product of a neuron starts from the bias instead of the old sum.
    if (dv_q) begin
      acc_d = (first_q ? sext_prod(b_data) : acc_q) + sext_prod(prod);
    end

    case (state_q)
      LOAD: begin
        if (in_valid) begin
          if (k_q == LAST_C) begin
            state_d = MAC;
            k_d     = '0;
            c_d     = '0;
            n_d     = '0;
            wa_d    = '0;
          end else begin
            k_d = k_q + CI_W'(1);
          end
        end
      end
      MAC: begin
        dv_d    = 1'b1;
        first_d = (c_q == '0);
        a_d     = buf_q[c_q];
        // Running address: after a neuron it already points at the next one.
        wa_d    = wa_q + WA_W'(1);
        if (c_q == LAST_C) begin
          state_d = DRAIN;
        end else begin
          c_d = c_q + CI_W'(1);
        end
      end
      DRAIN: begin
        state_d = QUANT;
      end
      QUANT: begin
        od_d    = q_val;
        oi_d    = n_q;
        ov_d    = 1'b1;
        state_d = OUT;
      end
      OUT: begin
        if (out_ready) begin
          ov_d = 1'b0;
          c_d  = '0;
          if (n_q == LAST_N) begin
            done_d  = 1'b1;
            k_d     = '0;
            state_d = LOAD;
          end else begin
            n_d     = n_q + BA_W'(1);
            state_d = MAC;
          end
        end
      end
      default: state_d = LOAD;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= LOAD;
      k_q     <= '0;
      c_q     <= '0;
      n_q     <= '0;
      wa_q    <= '0;
      dv_q    <= 1'b0;
      first_q <= 1'b0;
      a_q     <= '0;
      acc_q   <= '0;
      od_q    <= '0;
      oi_q    <= '0;
      ov_q    <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      c_q     <= c_d;
      n_q     <= n_d;
      wa_q    <= wa_d;
      dv_q    <= dv_d;
      first_q <= first_d;
      a_q     <= a_d;
      acc_q   <= acc_d;
      od_q    <= od_d;
      oi_q    <= oi_d;
      ov_q    <= ov_d;
      done_q  <= done_d;
    end
  end

  // Activation buffer has no reset; a new vector always overwrites every entry.
  always_ff @(posedge clk) begin
    if (!reset && state_q == LOAD && in_valid) begin
      buf_q[k_q] <= in_data;
    end
  end

  assign in_ready  = (state_q == LOAD);
  assign busy      = (state_q != LOAD);
  assign w_addr    = wa_q;
  assign b_addr    = n_q;
  assign out_valid = ov_q;
  assign out_data  = od_q;
  assign out_idx   = oi_q;
  assign done      = done_q;

`ifdef LAYER_SEQ_SAT_CNT_EN
  logic [15:0] sat_q, sat_d;

  always_comb begin
    sat_d = sat_q;
    if (state_q == QUANT && q_sat && sat_q != 16'hFFFF) begin
      sat_d = sat_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sat_q <= '0;
    end else begin
      sat_q <= sat_d;
    end
  end

  assign sat_cnt = sat_q;
`else
  logic unused_sat;
  assign unused_sat = q_sat;
`endif

endmodule

// File: tb/tb_layer_mac_sequencer.sv
module tb_layer_mac_sequencer;

  localparam int NUM_IN  = 30;
  localparam int NUM_OUT = 4;
  localparam int WA_W    = 7;
  localparam int BA_W    = 2;
  localparam int LAT     = NUM_IN + 3;

  logic                clk;
  logic                reset;
  logic                in_valid;
  logic                in_ready;
  logic signed [7:0]   in_data;
  logic [WA_W-1:0]     w_addr;
  logic signed [7:0]   w_data;
  logic [BA_W-1:0]     b_addr;
  logic signed [15:0]  b_data;
  logic                out_valid;
  logic                out_ready;
  logic [7:0]          out_data;
  logic [BA_W-1:0]     out_idx;
  logic                busy;
  logic                done;
`ifdef LAYER_SEQ_SAT_CNT_EN
  logic [15:0]         sat_cnt;
`endif

  layer_mac_sequencer #(
    .NUM_IN  (NUM_IN),
    .NUM_OUT (NUM_OUT)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .w_addr    (w_addr),
    .w_data    (w_data),
    .b_addr    (b_addr),
    .b_data    (b_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_idx   (out_idx),
    .busy      (busy),
    .done      (done)
`ifdef LAYER_SEQ_SAT_CNT_EN
    ,
    .sat_cnt   (sat_cnt)
`endif
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- ROM model (1-cycle read latency) ----------------
  logic signed [7:0]  w_rom [NUM_IN*NUM_OUT];
  logic signed [15:0] b_rom [NUM_OUT];

  always @(posedge clk) begin
    if (int'(w_addr) < NUM_IN * NUM_OUT) w_data <= w_rom[w_addr];
    else                                 w_data <= '0;
    b_data <= b_rom[b_addr];
  end

  // ---------------- vector table ----------------
  // ramp=0: every activation is a, every weight of neuron n is w[n].
  // ramp=1: activation c is c, neuron n has weight w[n] only at c=n+5.
  typedef struct {
    logic signed [7:0]   a;
    bit                  ramp;
    logic [3:0][7:0]     w;
    logic [3:0][15:0]    b;
    logic [3:0][7:0]     e;
    logic [3:0]          s;
  } vec_t;

  localparam int NROWS = 6;
  vec_t tbl [NROWS];

  int checks = 0;
  int errors = 0;
  int exp_sat = 0;

  task automatic set_row(input int r, input int a, input bit ramp,
                         input int w0, input int w1, input int w2, input int w3,
                         input int b0, input int b1, input int b2, input int b3,
                         input int e0, input int e1, input int e2, input int e3,
                         input logic [3:0] s);
    tbl[r].a    = 8'(a);
    tbl[r].ramp = ramp;
    tbl[r].w[0] = 8'(w0); tbl[r].w[1] = 8'(w1); tbl[r].w[2] = 8'(w2); tbl[r].w[3] = 8'(w3);
    tbl[r].b[0] = 16'(b0); tbl[r].b[1] = 16'(b1); tbl[r].b[2] = 16'(b2); tbl[r].b[3] = 16'(b3);
    tbl[r].e[0] = 8'(e0); tbl[r].e[1] = 8'(e1); tbl[r].e[2] = 8'(e2); tbl[r].e[3] = 8'(e3);
    tbl[r].s    = s;
  endtask

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Fill ROMs for row r and stream its activation vector into LOAD.
  task automatic prep_row(input int r);
    for (int n = 0; n < NUM_OUT; n++) begin
      b_rom[n] = tbl[r].b[n];
      for (int c = 0; c < NUM_IN; c++) begin
        if (tbl[r].ramp) w_rom[n*NUM_IN+c] = (c == n + 5) ? tbl[r].w[n] : 8'sd0;
        else             w_rom[n*NUM_IN+c] = tbl[r].w[n];
      end
    end
    for (int c = 0; c < NUM_IN; c++) begin
      in_valid = 1'b1;
      in_data  = tbl[r].ramp ? 8'(c) : tbl[r].a;
      step();
    end
    in_valid = 1'b0;
  endtask

  // Wait for out_valid; cyc is the cycle index relative to the accepting cycle.
  // Junk bytes are offered meanwhile; they must not reach the buffer.
  task automatic wait_out(output int cyc);
    cyc = 1;
    while (!out_valid && cyc < 200) begin
      in_valid = 1'b1;
      in_data  = 8'sh81;
      step();
      cyc++;
    end
    in_valid = 1'b0;
  endtask

  // Collect all neurons of row r; stall_len idle out_ready cycles at neuron stall_n.
  task automatic collect_row(input int r, input int stall_n, input int stall_len);
    int cyc;
    for (int n = 0; n < NUM_OUT; n++) begin
      wait_out(cyc);
      check("out_valid_seen", int'(out_valid), 1);
      check("latency", cyc, LAT);
      check("out_data", int'(out_data), int'(tbl[r].e[n]));
      check("out_idx", int'(out_idx), n);
      check("busy_out", int'(busy), 1);
      if (n == stall_n) begin
        for (int s = 0; s < stall_len; s++) begin
          in_valid = 1'b1;
          in_data  = 8'sh33;
          step();
          check("stall_valid", int'(out_valid), 1);
          check("stall_data", int'(out_data), int'(tbl[r].e[n]));
          check("stall_idx", int'(out_idx), n);
          check("stall_in_ready", int'(in_ready), 0);
        end
        in_valid = 1'b0;
      end
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
      check("done_pulse", int'(done), (n == NUM_OUT - 1) ? 1 : 0);
      check("valid_clear", int'(out_valid), 0);
    end
    step();
    check("done_low", int'(done), 0);
    check("in_ready_load", int'(in_ready), 1);
    check("busy_load", int'(busy), 0);
    exp_sat += $countones(tbl[r].s);
`ifdef LAYER_SEQ_SAT_CNT_EN
    check("sat_cnt", int'(sat_cnt), exp_sat);
`endif
  endtask

  initial begin
    //        r  a    rmp w0  w1  w2   w3   b0   b1    b2     b3    e0   e1   e2   e3   sat
    set_row(0, 1,   0, 64, 64, 64,  64,  0,   0,    0,     0,    30,  30,  30,  30,  4'b0000);
    set_row(1, 1,   0, -1, -1, -1,  -1,  0,   0,    0,     0,    0,   0,   0,   0,   4'b0000);
    set_row(2, 127, 0, 31, 31, 31,  31,  0,   0,    0,     0,    127, 127, 127, 127, 4'b1111);
    set_row(3, 1,   0, 0,  0,  0,   0,   32,  8191, -32,   100,  1,   127, 0,   2,   4'b0010);
    set_row(4, 2,   0, 10, -5, 100, 1,   0,   1000, -1000, 5000, 9,   11,  78,  79,  4'b0000);
    set_row(5, 0,   1, 64, 64, 64,  64,  32,  0,    0,     -64,  6,   6,   7,   7,   4'b0000);

    for (int i = 0; i < NUM_IN*NUM_OUT; i++) w_rom[i] = '0;
    for (int i = 0; i < NUM_OUT; i++) b_rom[i] = '0;

    reset     = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;
    repeat (3) step();
    reset = 1'b0;

    check("rst_in_ready", int'(in_ready), 1);
    check("rst_busy", int'(busy), 0);
    check("rst_out_valid", int'(out_valid), 0);
    check("rst_out_data", int'(out_data), 0);
    check("rst_out_idx", int'(out_idx), 0);
    check("rst_done", int'(done), 0);
`ifdef LAYER_SEQ_SAT_CNT_EN
    check("rst_sat_cnt", int'(sat_cnt), 0);
`endif

    // Table-driven vectors.
    for (int r = 0; r < NROWS; r++) begin
      prep_row(r);
      collect_row(r, -1, 0);
    end

    // Downstream stall: out_ready low 5 cycles at neuron 1.
    prep_row(0);
    collect_row(0, 1, 5);

    // Reset during MAC at c=10 aborts the vector.
    prep_row(2);
    for (int i = 0; i < 10; i++) begin
      in_valid = 1'b1;
      in_data  = 8'sh55;
      step();
    end
    in_valid = 1'b0;
    reset    = 1'b1;
    step();
    reset    = 1'b0;
    exp_sat  = 0;
    check("abort_in_ready", int'(in_ready), 1);
    check("abort_out_valid", int'(out_valid), 0);
    check("abort_busy", int'(busy), 0);
    check("abort_done", int'(done), 0);
`ifdef LAYER_SEQ_SAT_CNT_EN
    check("abort_sat_cnt", int'(sat_cnt), 0);
`endif
    // A fresh vector after the abort must evaluate correctly.
    prep_row(4);
    collect_row(4, -1, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
